// File: rtl/jesd_tx_pkg.sv
// Shared JESD204B TX link-layer types: link states, lane mux codes and the K-frame minimum table.
// Combinational helpers only: no latency, no flow control.
package jesd_tx_pkg;

  localparam int MUX_W  = 3;
  localparam int KMIN_W = 4;

  typedef enum logic [1:0] {
    ST_SYNC      = 2'd0,
    ST_INIT_LANE = 2'd1,
    ST_DATA_ENC  = 2'd2
  } link_state_e;

  localparam logic [MUX_W-1:0] MUX_USER_DATA = 3'd0;
  localparam logic [MUX_W-1:0] MUX_K         = 3'd1;
  localparam logic [MUX_W-1:0] MUX_ILA       = 3'd2;
  localparam logic [MUX_W-1:0] MUX_IDLE      = 3'd3;

  localparam logic [KMIN_W-1:0] KMIN_RESET = 4'd10;

  // f is octets-per-frame minus one; short frames need more K frames for CGS lock
  function automatic logic [KMIN_W-1:0] kmin_frames(input logic [7:0] f);
    logic [KMIN_W-1:0] k;
    if (f == 8'd0)       k = 4'd10;
    else if (f == 8'd1)  k = 4'd6;
    else if (f <= 8'd3)  k = 4'd4;
    else if (f <= 8'd7)  k = 4'd3;
    else                 k = 4'd2;
    return k;
  endfunction

endpackage

// File: rtl/jesd_tx_kmin_lut.sv
// Registered minimum-K-frame decode from the latched octets-per-frame value.
// Latency: one cycle from i_f to o_kmin; no flow control.
module jesd_tx_kmin_lut
  import jesd_tx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        i_f,
  output logic [KMIN_W-1:0] o_kmin
);

  logic [KMIN_W-1:0] kmin_q;
  logic [KMIN_W-1:0] kmin_d;

  always_comb begin
    kmin_d = kmin_frames(i_f);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) kmin_q <= KMIN_RESET;
    else        kmin_q <= kmin_d;
  end

  assign o_kmin = kmin_q;

endmodule

// File: rtl/jesd_tx_link_ctrl.sv
// Multi-lane JESD204B TX link controller: CGS -> ILA -> data, one FSM, per-lane mux selects.
// Outputs registered from next state (same edge as state); no backpressure. Option: JESD_TX_RELINK_CNT_EN.
module jesd_tx_link_ctrl #(
  parameter int LANES  = 4,
  parameter int KCNT_W = 5,
  parameter int MUX_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_clk,
  input  logic                   lmfc_clk,
  input  logic                   i_sync_request_tx,
  input  logic [LANES-1:0]       i_lane_en,
  input  logic [7:0]             i_F,
  input  logic [7:0]             i_ila_multiframe_length,
  output logic [LANES*MUX_W-1:0] o_link_mux,
  output logic [1:0]             o_state,
  output logic                   o_ila_start,
  output logic [7:0]             o_ila_mf_idx,
  output logic                   o_link_up
`ifdef JESD_TX_RELINK_CNT_EN
  ,
  output logic [15:0]            o_relink_cnt
`endif
);

  import jesd_tx_pkg::*;

  localparam logic [KCNT_W-1:0]      KCNT_MAX     = '1;
  localparam logic [MUX_W-1:0]       SEL_K        = MUX_W'(MUX_K);
  localparam logic [LANES*MUX_W-1:0] LINK_MUX_RST = {LANES{SEL_K}};

  link_state_e              state_q, state_d;
  logic [KCNT_W-1:0]        k_cnt_q, k_cnt_d;
  logic [7:0]               mf_cnt_q, mf_cnt_d;
  logic [7:0]               f_q, f_d;
  logic [7:0]               ila_len_q, ila_len_d;
  logic [LANES-1:0]         lane_en_q, lane_en_d;
  logic [LANES*MUX_W-1:0]   link_mux_q, link_mux_d;
  logic                     ila_start_q, ila_start_d;
  logic [7:0]               ila_mf_idx_q, ila_mf_idx_d;
  logic                     link_up_q, link_up_d;
  logic [KMIN_W-1:0]        kmin;
  logic                     k_ready;
  logic [MUX_W-1:0]         lane_code;

  jesd_tx_kmin_lut u_kmin_lut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_f    (f_q),
    .o_kmin (kmin)
  );

  assign k_ready = (k_cnt_q >= KCNT_W'(kmin));

  // Link parameters track the inputs only while the link is down
  always_comb begin
    f_d       = f_q;
    ila_len_d = ila_len_q;
    lane_en_d = lane_en_q;
    if (state_q == ST_SYNC) begin
      f_d       = i_F;
      ila_len_d = i_ila_multiframe_length;
      lane_en_d = i_lane_en;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_cnt_d  = k_cnt_q;
    mf_cnt_d = mf_cnt_q;
    case (state_q)
      ST_SYNC: begin
        if (i_sync_request_tx) begin
          k_cnt_d = '0;
        end else if (lmfc_clk && k_ready) begin
          state_d = ST_INIT_LANE;
          k_cnt_d = '0;
        end else if (frame_clk && (k_cnt_q != KCNT_MAX)) begin
          k_cnt_d = k_cnt_q + KCNT_W'(1);
        end
      end
      ST_INIT_LANE: begin
        if (i_sync_request_tx) begin
          state_d  = ST_SYNC;
          mf_cnt_d = '0;
        end else if (lmfc_clk) begin
          if (mf_cnt_q == ila_len_q) begin
            state_d  = ST_DATA_ENC;
            mf_cnt_d = '0;
          end else begin
            mf_cnt_d = mf_cnt_q + 8'd1;
          end
        end
      end
      ST_DATA_ENC: begin
        if (i_sync_request_tx) state_d = ST_SYNC;
      end
      default: begin
        state_d  = ST_SYNC;
        k_cnt_d  = '0;
        mf_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    lane_code = SEL_K;
    case (state_d)
      ST_INIT_LANE: lane_code = MUX_W'(MUX_ILA);
      ST_DATA_ENC:  lane_code = MUX_W'(MUX_USER_DATA);
      default:      lane_code = SEL_K;
    endcase
    link_mux_d = '0;
    for (int n = 0; n < LANES; n++) begin
      link_mux_d[n*MUX_W +: MUX_W] = lane_en_d[n] ? lane_code : MUX_W'(MUX_IDLE);
    end
    ila_start_d  = (state_d == ST_INIT_LANE) && (state_q != ST_INIT_LANE);
    ila_mf_idx_d = (state_d == ST_INIT_LANE) ? mf_cnt_d : 8'd0;
    link_up_d    = (state_d == ST_DATA_ENC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SYNC;
      k_cnt_q      <= '0;
      mf_cnt_q     <= '0;
      f_q          <= '0;
      ila_len_q    <= '0;
      lane_en_q    <= '1;
      link_mux_q   <= LINK_MUX_RST;
      ila_start_q  <= 1'b0;
      ila_mf_idx_q <= '0;
      link_up_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_cnt_q      <= k_cnt_d;
      mf_cnt_q     <= mf_cnt_d;
      f_q          <= f_d;
      ila_len_q    <= ila_len_d;
      lane_en_q    <= lane_en_d;
      link_mux_q   <= link_mux_d;
      ila_start_q  <= ila_start_d;
      ila_mf_idx_q <= ila_mf_idx_d;
      link_up_q    <= link_up_d;
    end
  end

  assign o_link_mux   = link_mux_q;
  assign o_state      = state_q;
  assign o_ila_start  = ila_start_q;
  assign o_ila_mf_idx = ila_mf_idx_q;
  assign o_link_up    = link_up_q;

`ifdef JESD_TX_RELINK_CNT_EN
  logic [15:0] relink_cnt_q, relink_cnt_d;
  logic        relink;

  // Any drop back to SYNC from an active link state counts as a relink
  always_comb begin
    relink       = (state_q != ST_SYNC) && (state_d == ST_SYNC);
    relink_cnt_d = relink_cnt_q;
    if (relink && (relink_cnt_q != 16'hFFFF)) relink_cnt_d = relink_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) relink_cnt_q <= '0;
    else        relink_cnt_q <= relink_cnt_d;
  end

  assign o_relink_cnt = relink_cnt_q;
`endif

endmodule
